alarm_trigger_ctrl: RTL

//  Decides when the alarm overlay must be shown; drives the RING overlay's activar_alarma input.

---
 rtl/rtc_alarm_pkg.sv | 31 +++
 rtl/rise_detect.sv | 31 +++
 rtl/alarm_trigger_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rtc_alarm_pkg.sv
// -----------------------------------------------------------------------------
// rtc_alarm_pkg
// Shared definitions for the RTC countdown alarm path:
//   - alarm FSM state encoding (also exported on alarm_state)
//   - default ring timeout in frames
//   - packed-BCD validity helpers
// -----------------------------------------------------------------------------
package rtc_alarm_pkg;

    // Alarm FSM states; the encodings are visible to software via alarm_state.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SILENCED = 2'd3
    } alarm_state_e;

    // 600 frames = 10 s at 60 Hz.
    localparam logic [15:0] DEFAULT_TIMEOUT_FRAMES = 16'd600;

    // One BCD digit is valid when it lies in 0..9.
    function automatic logic bcd_digit_ok(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

    // A packed-BCD byte is valid when both of its digits are valid.
    function automatic logic bcd_byte_ok(input logic [7:0] bcd);
        return bcd_digit_ok(bcd[7:4]) && bcd_digit_ok(bcd[3:0]);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// 1-bit rising-edge detector. The input is registered once on clk and the
// output flags a cycle where the input is high but was low one cycle earlier.
// Ports:
//   clk    in  1  clock, posedge
//   reset  in  1  synchronous, active-high; clears the history register
//   i_d    in  1  level input (already synchronised/debounced)
//   o_rise out 1  i_d & ~i_d delayed by one cycle
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_d_q;

    // History register: input value seen on the previous clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_q <= 1'b0;
        end else begin
            r_d_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_d_q;

endmodule

// File: rtl/alarm_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_trigger_ctrl
// Decides when the alarm overlay is shown. Watches BCD countdown readings from
// the RTC reader and rings when an armed countdown reaches 00:00:00. Ringing
// ends on an acknowledge press or after TIMEOUT_FRAMES frames.
// Ports:
//   clk            in   1  pixel clock, posedge
//   reset          in   1  synchronous, active-high
//   frame_tick     in   1  one pulse per frame
//   timer_valid    in   1  strobe: timer_hh/mm/ss hold a fresh reading
//   timer_hh/mm/ss in   8  countdown value, packed BCD
//   timer_running  in   1  countdown enabled in RTC
//   ack_btn        in   1  debounced acknowledge button, level
//   activar_alarma out  1  high while RINGING (registered)
//   alarm_state    out  2  current FSM state
//   alarm_count    out  8  RINGING entries since reset, saturating at 255
// -----------------------------------------------------------------------------
module alarm_trigger_ctrl
    import rtc_alarm_pkg::*;
#(
    parameter int unsigned          CNT_W          = 16,
    parameter logic [CNT_W-1:0]     TIMEOUT_FRAMES = DEFAULT_TIMEOUT_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       timer_valid,
    input  logic [7:0] timer_hh,
    input  logic [7:0] timer_mm,
    input  logic [7:0] timer_ss,
    input  logic       timer_running,
    input  logic       ack_btn,
    output logic       activar_alarma,
    output logic [1:0] alarm_state,
    output logic [7:0] alarm_count
);

    // Last frame count before timeout; wraps harmlessly when TIMEOUT_FRAMES is
    // zero because the timeout term is gated off in that case.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_FRAMES - {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             TIMEOUT_EN   = (TIMEOUT_FRAMES != {CNT_W{1'b0}});

    alarm_state_e     r_state;
    alarm_state_e     w_next_state;
    logic             r_activar;
    logic [7:0]       r_alarm_count;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_ack_rise;
    logic             w_sample_ok;
    logic             w_is_zero;
    logic             w_is_nonzero;
    logic             w_timeout;
    logic             w_enter_ringing;

    rise_detect u_ack_rise (
        .clk    (clk),
        .reset  (reset),
        .i_d    (ack_btn),
        .o_rise (w_ack_rise)
    );

    // Reading qualification: a strobe with any non-decimal digit is dropped.
    assign w_sample_ok  = timer_valid & bcd_byte_ok(timer_hh)
                                      & bcd_byte_ok(timer_mm)
                                      & bcd_byte_ok(timer_ss);
    assign w_is_zero    = w_sample_ok & (timer_hh == 8'h00)
                                      & (timer_mm == 8'h00)
                                      & (timer_ss == 8'h00);
    assign w_is_nonzero = w_sample_ok & ~w_is_zero;

    assign w_timeout = TIMEOUT_EN & frame_tick & (r_frame_cnt == TIMEOUT_LAST);

    // Next-state logic; within each state the earlier test has priority.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // A zero reading here never fires: avoids ringing at power-up.
                if (timer_running & w_is_nonzero) begin
                    w_next_state = ST_ARMED;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (~timer_running) begin
                    w_next_state = ST_IDLE;
                end else if (w_is_zero) begin
                    w_next_state = ST_RINGING;
                end else begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_RINGING: begin
                if (w_ack_rise | w_timeout) begin
                    w_next_state = ST_SILENCED;
                end else begin
                    w_next_state = ST_RINGING;
                end
            end
            ST_SILENCED: begin
                if (~timer_running) begin
                    w_next_state = ST_IDLE;
                end else if (w_is_nonzero) begin
                    w_next_state = ST_ARMED;
                end else begin
                    w_next_state = ST_SILENCED;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_enter_ringing = (w_next_state == ST_RINGING) && (r_state != ST_RINGING);

    // State register and registered overlay enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_activar <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_activar <= (w_next_state == ST_RINGING);
        end
    end

    // Ring-duration frame counter: restarts on entry, counts ticks while ringing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= {CNT_W{1'b0}};
        end else if (w_enter_ringing) begin
            r_frame_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == ST_RINGING) && frame_tick) begin
            r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    // Saturating count of ARMED->RINGING transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm_count <= 8'd0;
        end else if ((r_state == ST_ARMED) && (w_next_state == ST_RINGING)
                     && (r_alarm_count != 8'd255)) begin
            r_alarm_count <= r_alarm_count + 8'd1;
        end else begin
            r_alarm_count <= r_alarm_count;
        end
    end

    assign activar_alarma = r_activar;
    assign alarm_state    = r_state;
    assign alarm_count    = r_alarm_count;

endmodule
